freq_bcd_converter: RTL and testbench

Consumes the 32-bit Frequency count produced by the frequency meter and converts it to packed BCD for the seven-segment display driver. It uses a sequential double-dabble process: one bit per clock, with an add-3 adjust on every digit. Results are held in a shadow register so the display never sees partial values. It also produces a leading-zero blanking mask and an overflow flag for values the display cannot show.

---
 rtl/freq_meter_pkg.sv | 25 ++
 rtl/freq_bcd_converter_if.sv | 27 ++
 rtl/freq_bcd_converter_bcd_digit_adj.sv | 11 +
 rtl/freq_bcd_converter.sv | 114 +++++++++++
 tb/tb_freq_bcd_converter.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/freq_meter_pkg.sv
`default_nettype none
// ============================================================================
// freq_meter_pkg : shared types and constants for the BCD converter  | rev 1.0
// ============================================================================
package freq_meter_pkg;

    localparam int c_BCD_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    function automatic logic [63:0] pow10(input int n);
        logic [63:0] r;
        r = 64'd1;
        for (int i = 0; i < n; i++) begin
            r = r * 64'd10;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/freq_bcd_converter_if.sv
`default_nettype none
// ============================================================================
// freq_bcd_converter_if : request/result bundle of the BCD converter | rev 1.0
// ============================================================================
interface freq_bcd_converter_if #(
    parameter int WIDTH  = 32,
    parameter int DIGITS = 8
);
    logic [WIDTH-1:0]    freq_in;
    logic                start;
    logic                busy;
    logic                done;
    logic [4*DIGITS-1:0] bcd_out;
    logic [DIGITS-1:0]   digit_en;
    logic                overflow;

    modport master (
        output freq_in, start,
        input  busy, done, bcd_out, digit_en, overflow
    );

    modport slave (
        input  freq_in, start,
        output busy, done, bcd_out, digit_en, overflow
    );
endinterface
`default_nettype wire

// File: rtl/freq_bcd_converter_bcd_digit_adj.sv
`default_nettype none
// ============================================================================
// bcd_digit_adj : double-dabble digit correction (+3 when >= 5)      | rev 1.0
// ============================================================================
module bcd_digit_adj (
    input  wire logic [3:0] i_digit,
    output logic      [3:0] o_digit
);
    assign o_digit = (i_digit >= 4'd5) ? (i_digit + 4'd3) : i_digit;
endmodule
`default_nettype wire

// File: rtl/freq_bcd_converter.sv
`default_nettype none
// ============================================================================
// freq_bcd_converter : sequential binary-to-BCD with blanking/overflow | rev 1.0
// ============================================================================
module freq_bcd_converter
    import freq_meter_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int DIGITS = 8
) (
    input  wire logic            clk,
    input  wire logic            rst_n,
    freq_bcd_converter_if.slave  bus
);
    localparam int          c_SW    = c_BCD_W * DIGITS;
    localparam int          c_CW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [63:0] c_LIMIT = pow10(DIGITS);

    state_t            r_state;
    logic [WIDTH-1:0]  r_shift;
    logic [c_SW-1:0]   r_scratch;
    logic [c_CW-1:0]   r_cnt;
    logic              r_ovf_pend;
    logic              r_busy;
    logic              r_done;
    logic [c_SW-1:0]   r_bcd;
    logic [DIGITS-1:0] r_digit_en;
    logic              r_overflow;

    logic [c_SW-1:0]   w_adj;
    logic [DIGITS-1:0] w_digit_en;
    logic              w_any;
    logic              w_over;

    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_adj
            bcd_digit_adj u_adj (
                .i_digit (r_scratch[c_BCD_W*gi +: c_BCD_W]),
                .o_digit (w_adj[c_BCD_W*gi +: c_BCD_W])
            );
        end
    endgenerate

    // When the limit exceeds the input range this compare is constant false.
    assign w_over = (64'(bus.freq_in) >= c_LIMIT);

    // Digit i is lit when it or any more significant digit is nonzero.
    always_comb begin
        w_any      = 1'b0;
        w_digit_en = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            w_any         = w_any | (|r_scratch[c_BCD_W*i +: c_BCD_W]);
            w_digit_en[i] = w_any;
        end
        w_digit_en[0] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_shift    <= '0;
            r_scratch  <= '0;
            r_cnt      <= '0;
            r_ovf_pend <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_bcd      <= '0;
            r_digit_en <= {{(DIGITS-1){1'b0}}, 1'b1};
            r_overflow <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_shift    <= bus.freq_in;
                        r_scratch  <= '0;
                        r_cnt      <= '0;
                        r_busy     <= 1'b1;
                        r_ovf_pend <= w_over;
                        r_state    <= w_over ? ST_DONE : ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    {r_scratch, r_shift} <= {w_adj, r_shift} << 1;
                    r_cnt                <= r_cnt + 1'b1;
                    if (r_cnt == c_CW'(WIDTH - 1)) begin
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_bcd      <= r_ovf_pend ? {DIGITS{4'h9}} : r_scratch;
                    r_digit_en <= r_ovf_pend ? {DIGITS{1'b1}} : w_digit_en;
                    r_overflow <= r_ovf_pend;
                    r_done     <= 1'b1;
                    r_busy     <= 1'b0;
                    r_state    <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.bcd_out  = r_bcd;
    assign bus.digit_en = r_digit_en;
    assign bus.overflow = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_freq_bcd_converter.sv
`default_nettype none
// ============================================================================
// tb_freq_bcd_converter : randomized self-checking bench, decimal model | rev 1.0
// ============================================================================
module tb_freq_bcd_converter;
    localparam int WIDTH  = 32;
    localparam int DIGITS = 8;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    freq_bcd_converter_if #(.WIDTH(WIDTH), .DIGITS(DIGITS)) bus ();

    freq_bcd_converter #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    function automatic longint limit();
        longint p = 1;
        for (int i = 0; i < DIGITS; i++) p = p * 10;
        return limit_ret(p);
    endfunction
    function automatic longint limit_ret(input longint p);
        return p;
    endfunction

    function automatic logic [4*DIGITS-1:0] ref_bcd(input longint v);
        logic [4*DIGITS-1:0] r;
        longint t = v;
        r = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (v >= limit()) r[4*i +: 4] = 4'd9;
            else begin
                r[4*i +: 4] = 4'(t % 10);
                t = t / 10;
            end
        end
        return r;
    endfunction

    function automatic logic [DIGITS-1:0] ref_en(input longint v);
        logic [DIGITS-1:0] e;
        longint p = 1;
        for (int i = 0; i < DIGITS; i++) begin
            e[i] = (v >= limit()) || (i == 0) || (v >= p);
            p = p * 10;
        end
        return e;
    endfunction

    function automatic int ref_lat(input longint v);
        return (v >= limit()) ? 1 : WIDTH + 1;
    endfunction

    // Drives one Start pulse and measures latency and busy duration.
    task automatic run_conversion(input logic [WIDTH-1:0] v, output int lat,
                                  output int busy_cyc, output bit timed_out);
        @(negedge clk);
        bus.freq_in = v;
        bus.start   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start   = 1'b0;
        bus.freq_in = $urandom;
        busy_cyc  = bus.busy ? 1 : 0;
        lat       = 0;
        timed_out = 1'b0;
        forever begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (bus.done) break;
            if (bus.busy) busy_cyc++;
            if (lat > 200) begin
                timed_out = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        tests_run += 5;
        if (bus.busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy got %b exp 0", bus.busy); end
        if (bus.done !== 1'b0) begin tests_failed++; $display("FAIL reset_done got %b exp 0", bus.done); end
        if (bus.bcd_out !== '0) begin tests_failed++; $display("FAIL reset_bcd got %h exp 0", bus.bcd_out); end
        if (bus.digit_en !== 8'h01) begin tests_failed++; $display("FAIL reset_en got %h exp 01", bus.digit_en); end
        if (bus.overflow !== 1'b0) begin tests_failed++; $display("FAIL reset_ovf got %b exp 0", bus.overflow); end
    endtask

    task automatic test_directed();
        logic [WIDTH-1:0] vals [7] = '{32'd0, 32'd12345678, 32'd1000, 32'd99999999,
                                       32'd100000000, 32'hFFFFFFFF, 32'd5};
        int lat, bc;
        bit to;
        for (int k = 0; k < 7; k++) begin
            longint v = longint'(vals[k]);
            run_conversion(vals[k], lat, bc, to);
            tests_run += 8;
            if (to) begin tests_failed++; $display("FAIL dir_timeout val %0d no done", v); end
            if (lat != ref_lat(v)) begin tests_failed++; $display("FAIL dir_latency val %0d got %0d exp %0d", v, lat, ref_lat(v)); end
            if (bc != ref_lat(v)) begin tests_failed++; $display("FAIL dir_busy_len val %0d got %0d exp %0d", v, bc, ref_lat(v)); end
            if (bus.busy !== 1'b0) begin tests_failed++; $display("FAIL dir_busy_at_done val %0d got %b exp 0", v, bus.busy); end
            if (bus.bcd_out !== ref_bcd(v)) begin tests_failed++; $display("FAIL dir_bcd val %0d got %h exp %h", v, bus.bcd_out, ref_bcd(v)); end
            if (bus.digit_en !== ref_en(v)) begin tests_failed++; $display("FAIL dir_en val %0d got %h exp %h", v, bus.digit_en, ref_en(v)); end
            if (bus.overflow !== (v >= limit())) begin tests_failed++; $display("FAIL dir_ovf val %0d got %b exp %b", v, bus.overflow, v >= limit()); end
            @(negedge clk);
            if (bus.done !== 1'b0) begin tests_failed++; $display("FAIL dir_done_width val %0d done still %b", v, bus.done); end
        end
    endtask

    task automatic test_random();
        int lat, bc;
        bit to;
        logic [WIDTH-1:0] x;
        for (int k = 0; k < 24; k++) begin
            longint v;
            case ($urandom_range(0, 3))
                0:       x = $urandom;
                1:       x = $urandom_range(0, 99999999);
                2:       x = $urandom_range(0, 99999999) >> $urandom_range(0, 26);
                default: x = 32'd99999998 + $urandom_range(0, 3);
            endcase
            v = longint'(x);
            run_conversion(x, lat, bc, to);
            tests_run += 4;
            if (to || lat != ref_lat(v)) begin tests_failed++; $display("FAIL rnd_latency val %0d got %0d exp %0d", v, lat, ref_lat(v)); end
            if (bus.bcd_out !== ref_bcd(v)) begin tests_failed++; $display("FAIL rnd_bcd val %0d got %h exp %h", v, bus.bcd_out, ref_bcd(v)); end
            if (bus.digit_en !== ref_en(v)) begin tests_failed++; $display("FAIL rnd_en val %0d got %h exp %h", v, bus.digit_en, ref_en(v)); end
            if (bus.overflow !== (v >= limit())) begin tests_failed++; $display("FAIL rnd_ovf val %0d got %b", v, bus.overflow); end
        end
    endtask

    task automatic test_hold();
        int lat, bc;
        bit to;
        int bad = 0;
        run_conversion(32'd4321, lat, bc, to);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            bus.freq_in = $urandom;
            if (bus.bcd_out !== ref_bcd(4321) || bus.done !== 1'b0 || bus.busy !== 1'b0) bad++;
        end
        tests_run++;
        if (bad != 0) begin tests_failed++; $display("FAIL hold got bcd %h in %0d bad cycles exp %h", bus.bcd_out, bad, ref_bcd(4321)); end
    endtask

    task automatic test_back_to_back();
        logic [WIDTH-1:0] vals [141];
        int dones = 0;
        for (int i = 0; i < 141; i++) begin
            @(negedge clk);
            if (i >= 34 && (i % 34) == 0) begin
                longint v = longint'(vals[i-34]);
                tests_run += 2;
                if (bus.done !== 1'b1) begin tests_failed++; $display("FAIL b2b_done cycle %0d got %b exp 1", i, bus.done); end
                if (bus.bcd_out !== ref_bcd(v) || bus.digit_en !== ref_en(v)) begin
                    tests_failed++;
                    $display("FAIL b2b_result cycle %0d got %h/%h exp %h/%h", i, bus.bcd_out, bus.digit_en, ref_bcd(v), ref_en(v));
                end
            end else if (bus.done === 1'b1) begin
                tests_run++;
                tests_failed++;
                $display("FAIL b2b_extra_done cycle %0d got 1 exp 0", i);
            end
            if (bus.done === 1'b1) dones++;
            vals[i]     = $urandom_range(0, 99999999);
            bus.freq_in = vals[i];
            bus.start   = 1'b1;
        end
        bus.start = 1'b0;
        tests_run++;
        if (dones != 4) begin tests_failed++; $display("FAIL b2b_done_count got %0d exp 4", dones); end
        for (int k = 0; k < 60 && bus.busy; k++) @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int lat, bc;
        bit to;
        int seen = 0;
        run_conversion(32'd87654321, lat, bc, to);
        @(negedge clk);
        bus.freq_in = 32'd12345678;
        bus.start   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (10) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        tests_run += 4;
        if (bus.busy !== 1'b0) begin tests_failed++; $display("FAIL midrst_busy got %b exp 0", bus.busy); end
        if (bus.bcd_out !== '0) begin tests_failed++; $display("FAIL midrst_bcd got %h exp 0", bus.bcd_out); end
        if (bus.digit_en !== 8'h01) begin tests_failed++; $display("FAIL midrst_en got %h exp 01", bus.digit_en); end
        if (bus.overflow !== 1'b0 || bus.done !== 1'b0) begin tests_failed++; $display("FAIL midrst_flags got ovf %b done %b exp 0 0", bus.overflow, bus.done); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (bus.done === 1'b1) seen++;
        end
        tests_run++;
        if (seen != 0) begin tests_failed++; $display("FAIL midrst_no_done got %0d pulses exp 0", seen); end
        run_conversion(32'd12345678, lat, bc, to);
        tests_run += 2;
        if (to || lat != WIDTH + 1) begin tests_failed++; $display("FAIL midrst_relat got %0d exp %0d", lat, WIDTH + 1); end
        if (bus.bcd_out !== 32'h12345678 || bus.digit_en !== 8'hFF) begin
            tests_failed++;
            $display("FAIL midrst_reconv got %h/%h exp 12345678/ff", bus.bcd_out, bus.digit_en);
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        bus.start   = 1'b0;
        bus.freq_in = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        test_reset();
        test_directed();
        test_random();
        test_hold();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire
